// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : M-stage data-memory responder for the pipelined MIPS core;
//            word-organised RAM with byte-enabled stores and programmable
//            wait states. Deasserts ready to stall the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [3:0]  mem_be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        error
);

    localparam int       AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] C_LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] ram [DEPTH];

    logic          w_bad;
    logic          w_fire;
    logic          w_wr;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rword;

    assign w_bad   = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));
    assign w_idx   = addr[AW+1:2];
    assign w_rword = ram[w_idx];

    // The request cycle in IDLE is the first stall cycle, so a LATENCY of N
    // spends N-1 cycles in WAIT and LATENCY=1 goes straight to DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_fire  = 1'b0;
        ready   = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (mem_en) begin
                    if (LATENCY == 0) begin
                        w_fire = 1'b1;
                    end else begin
                        ready   = 1'b0;
                        cnt_d   = C_LAT_M1;
                        state_d = (LATENCY == 1) ? S_DONE : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                ready = 1'b0;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                w_fire  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (rst) begin
            ready  = 1'b1;
            w_fire = 1'b0;
        end
    end

    assign w_wr  = w_fire && mem_we && !w_bad;
    assign rdata = (w_fire && !mem_we && !w_bad) ? w_rword : 32'd0;
    assign error = w_fire && w_bad;

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clka) begin
        if (w_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    ram[w_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
